// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared types and constants for the RGMII receive decoder.
// Rev 1.0 - initial release
`default_nettype none

package rgmii_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    LOW_NIB   = 3'd2,
    HIGH_NIB  = 3'd3,
    GIG       = 3'd4
  } frame_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rgmii_inband_status.sv
// rgmii_inband_status: two-sample filter for RGMII in-band link status (built under RGMII_INBAND_STATUS_EN).
// Rev 1.0 - initial release
`default_nettype none

module rgmii_inband_status
  import rgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dv,
  input  logic       er,
  input  logic [3:0] rxd,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  logic [3:0] last_rxd;
  logic       last_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rxd    <= 4'h0;
      last_ok     <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= SPEED_10;
      full_duplex <= 1'b0;
    end else if (dv) begin
      last_ok <= 1'b0;
    end else if (!er) begin
      // Carrier-extend/error cycles fall through untouched, keeping the pair intact.
      if (last_ok && (rxd == last_rxd)) begin
        link_up     <= rxd[0];
        link_speed  <= rxd[2:1];
        full_duplex <= rxd[3];
      end
      last_rxd <= rxd;
      last_ok  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: RGMII DDR sample pairs to GIGMII byte stream with SFD strobe and in-band status.
// Rev 1.0 - initial release. Optional in-band status filter: define RGMII_INBAND_STATUS_EN.
`default_nettype none

module rgmii_rx_decode
  import rgmii_pkg::*;
#(
  parameter int SFD_DETECT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] q1,
  input  logic [4:0] q2,
  input  logic       mii_select,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_dv,
  output logic       rx_er,
  output logic       sfd_pulse,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  logic dv;
  logic er;
  assign dv = q1[4];
  assign er = q1[4] ^ q2[4];

  frame_state_e state, state_next;
  logic [3:0]   low_nib, low_nib_next;
  logic         low_er, low_er_next;
  logic         emit;
  logic [7:0]   byte_val;
  logic         byte_er;

  // The dv-rising cycle already carries the first sample, so IDLE processes it as
  // the first GIG/LOW_NIB cycle; the frame mode then lives in the state itself.
  always_comb begin
    state_next   = state;
    low_nib_next = low_nib;
    low_er_next  = low_er;
    emit         = 1'b0;
    byte_val     = rx_data;
    byte_er      = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (!dv) state_next = IDLE;
      end
      IDLE: begin
        if (dv) begin
          if (mii_select) begin
            low_nib_next = q1[3:0];
            low_er_next  = er;
            state_next   = HIGH_NIB;
          end else begin
            emit       = 1'b1;
            byte_val   = {q2[3:0], q1[3:0]};
            byte_er    = er;
            state_next = GIG;
          end
        end
      end
      LOW_NIB: begin
        if (dv) begin
          low_nib_next = q1[3:0];
          low_er_next  = er;
          state_next   = HIGH_NIB;
        end else begin
          state_next = IDLE;
        end
      end
      HIGH_NIB: begin
        emit = 1'b1;
        if (dv) begin
          byte_val   = {q1[3:0], low_nib};
          byte_er    = low_er | er;
          state_next = LOW_NIB;
        end else begin
          // Odd nibble count: flush the orphan nibble flagged as an error.
          byte_val   = {4'h0, low_nib};
          byte_er    = 1'b1;
          state_next = IDLE;
        end
      end
      GIG: begin
        if (dv) begin
          emit     = 1'b1;
          byte_val = {q2[3:0], q1[3:0]};
          byte_er  = er;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_IDLE;
      low_nib  <= 4'h0;
      low_er   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_dv    <= 1'b0;
      rx_er    <= 1'b0;
    end else begin
      state    <= state_next;
      low_nib  <= low_nib_next;
      low_er   <= low_er_next;
      rx_valid <= emit;
      rx_dv    <= emit;
      rx_er    <= emit & byte_er;
      if (emit) rx_data <= byte_val;
    end
  end

  generate
    if (SFD_DETECT != 0) begin : g_sfd
      logic pre_seen, disarmed, seen_now, dis_now;

      assign seen_now = (state == IDLE) ? 1'b0 : pre_seen;
      assign dis_now  = (state == IDLE) ? 1'b0 : disarmed;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre_seen  <= 1'b0;
          disarmed  <= 1'b0;
          sfd_pulse <= 1'b0;
        end else begin
          sfd_pulse <= emit && !dis_now && seen_now && (byte_val == SFD_BYTE);
          if (emit && !dis_now) begin
            pre_seen <= seen_now | (byte_val == PREAMBLE_BYTE);
            disarmed <= (byte_val != PREAMBLE_BYTE);
          end else if (state == IDLE || state == WAIT_IDLE) begin
            pre_seen <= 1'b0;
            disarmed <= 1'b0;
          end
        end
      end
    end else begin : g_no_sfd
      assign sfd_pulse = 1'b0;
    end
  endgenerate

`ifdef RGMII_INBAND_STATUS_EN
  rgmii_inband_status u_status (
    .clk         (clk),
    .rst_n       (rst_n),
    .dv          (dv),
    .er          (er),
    .rxd         (q1[3:0]),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .full_duplex (full_duplex)
  );
`else
  assign link_up     = 1'b0;
  assign link_speed  = SPEED_10;
  assign full_duplex = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: directed self-checking bench for rgmii_rx_decode.
// Rev 1.0 - initial release
`default_nettype none

module tb_rgmii_rx_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] q1 = 5'h00;
  logic [4:0] q2 = 5'h00;
  logic       mii_select = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_dv, rx_er, sfd_pulse;
  logic       link_up, full_duplex;
  logic [1:0] link_speed;

  int checks = 0;
  int errors = 0;
  logic [3:0] idle_nib = 4'h0;

  rgmii_rx_decode #(.SFD_DETECT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q1          (q1),
    .q2          (q2),
    .mii_select  (mii_select),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_dv       (rx_dv),
    .rx_er       (rx_er),
    .sfd_pulse   (sfd_pulse),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .full_duplex (full_duplex)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [4:0] a, input logic [4:0] b);
    q1 = a;
    q2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc({1'b0, idle_nib}, {1'b0, idle_nib});
  endtask

  task automatic gig(input logic [7:0] v);
    cyc({1'b1, v[3:0]}, {1'b1, v[7:4]});
  endtask

  task automatic nib(input logic [3:0] n);
    cyc({1'b1, n}, {1'b1, n});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    idle();
    checks++;
    if ({rx_valid, rx_dv, rx_er, sfd_pulse, rx_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_frame_outs got v%b dv%b er%b sfd%b data %h required all 0",
               rx_valid, rx_dv, rx_er, sfd_pulse, rx_data);
    end
    checks++;
    if ({link_up, link_speed, full_duplex} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status got link%b speed%b dup%b required 0 00 0",
               link_up, link_speed, full_duplex);
    end
    rst_n = 1'b1;
    idle();
    idle();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset rx_valid got %b required 0", rx_valid);
    end
  endtask

  task automatic test_gig_frame();
    logic [7:0] exp;
    mii_select = 1'b0;
    for (int i = 0; i < 72; i++) begin
      exp = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(i - 7);
      gig(exp);
      checks++;
      if (rx_valid !== 1'b1 || rx_dv !== 1'b1 || rx_data !== exp) begin
        errors++;
        $display("FAIL gig_byte[%0d] got v%b dv%b data %h required v1 dv1 data %h",
                 i, rx_valid, rx_dv, rx_data, exp);
      end
      checks++;
      if (rx_er !== 1'b0 || sfd_pulse !== (i == 7)) begin
        errors++;
        $display("FAIL gig_flags[%0d] got er%b sfd%b required er0 sfd%b",
                 i, rx_er, sfd_pulse, (i == 7));
      end
    end
    idle();
    checks++;
    if (rx_valid !== 1'b0 || rx_dv !== 1'b0 || rx_data !== 8'h40) begin
      errors++;
      $display("FAIL gig_end got v%b dv%b data %h required v0 dv0 data 40",
               rx_valid, rx_dv, rx_data);
    end
    idle();
  endtask

  task automatic test_mii_frame();
    logic [7:0] mb [13];
    for (int i = 0; i < 8; i++) mb[i] = 8'h55;
    mb[8] = 8'hD5; mb[9] = 8'h12; mb[10] = 8'h34; mb[11] = 8'hAB; mb[12] = 8'hCD;
    mii_select = 1'b1;
    for (int i = 0; i < 13; i++) begin
      nib(mb[i][3:0]);
      checks++;
      if (rx_valid !== 1'b0 || rx_dv !== 1'b0 || (i > 0 && rx_data !== mb[i-1])) begin
        errors++;
        $display("FAIL mii_low[%0d] got v%b dv%b data %h required v0 dv0 held data",
                 i, rx_valid, rx_dv, rx_data);
      end
      nib(mb[i][7:4]);
      checks++;
      if (rx_valid !== 1'b1 || rx_dv !== 1'b1 || rx_er !== 1'b0 || rx_data !== mb[i]
          || sfd_pulse !== (i == 8)) begin
        errors++;
        $display("FAIL mii_byte[%0d] got v%b dv%b er%b sfd%b data %h required v1 dv1 er0 sfd%b data %h",
                 i, rx_valid, rx_dv, rx_er, sfd_pulse, rx_data, (i == 8), mb[i]);
      end
    end
    idle();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mii_end rx_valid got %b required 0", rx_valid);
    end
    idle();
    mii_select = 1'b0;
  endtask

  task automatic test_mii_odd();
    logic [3:0] ns [11];
    ns = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    mii_select = 1'b1;
    for (int i = 0; i < 11; i++) nib(ns[i]);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mii_odd_pending rx_valid got %b required 0", rx_valid);
    end
    idle();
    checks++;
    if (rx_valid !== 1'b1 || rx_dv !== 1'b1 || rx_er !== 1'b1 || rx_data[3:0] !== 4'h7) begin
      errors++;
      $display("FAIL mii_dribble got v%b dv%b er%b low %h required v1 dv1 er1 low 7",
               rx_valid, rx_dv, rx_er, rx_data[3:0]);
    end
    idle();
    checks++;
    if (rx_valid !== 1'b0 || rx_er !== 1'b0) begin
      errors++;
      $display("FAIL mii_after_dribble got v%b er%b required v0 er0", rx_valid, rx_er);
    end
    mii_select = 1'b0;
    idle();
  endtask

  task automatic test_gig_error();
    logic [7:0] exp;
    mii_select = 1'b0;
    for (int i = 0; i < 24; i++) begin
      exp = 8'hA0 + 8'(i);
      if (i == 10) mii_select = 1'b1;
      if (i == 19) cyc({1'b1, exp[3:0]}, {1'b0, exp[7:4]});
      else gig(exp);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp || rx_er !== (i == 19)) begin
        errors++;
        $display("FAIL gig_err[%0d] got v%b data %h er%b required v1 data %h er%b",
                 i, rx_valid, rx_data, rx_er, exp, (i == 19));
      end
    end
    mii_select = 1'b0;
    idle();
    idle();
  endtask

  task automatic test_inband();
    idle_nib = 4'b1101;
    idle();
    checks++;
    if (link_up !== 1'b0) begin
      errors++;
      $display("FAIL inband_single link_up got %b required 0", link_up);
    end
    idle();
`ifdef RGMII_INBAND_STATUS_EN
    checks++;
    if ({link_up, link_speed, full_duplex} !== 4'b1101) begin
      errors++;
      $display("FAIL inband_pair got link%b speed%b dup%b required 1 10 1",
               link_up, link_speed, full_duplex);
    end
    idle_nib = 4'b0000;
    idle();
    idle_nib = 4'b1101;
    idle();
    checks++;
    if ({link_up, link_speed, full_duplex} !== 4'b1101) begin
      errors++;
      $display("FAIL inband_glitch got link%b speed%b dup%b required 1 10 1",
               link_up, link_speed, full_duplex);
    end
    idle_nib = 4'b0011;
    idle();
    cyc(5'b0_0110, 5'b1_0110);
    idle();
    checks++;
    if ({link_up, link_speed, full_duplex} !== 4'b1010) begin
      errors++;
      $display("FAIL inband_extend got link%b speed%b dup%b required 1 01 0",
               link_up, link_speed, full_duplex);
    end
    idle_nib = 4'b1101;
    idle();
    idle();
`else
    checks++;
    if ({link_up, link_speed, full_duplex} !== 4'b0000) begin
      errors++;
      $display("FAIL inband_disabled got link%b speed%b dup%b required 0 00 0",
               link_up, link_speed, full_duplex);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    mii_select = 1'b0;
    for (int i = 0; i < 5; i++) gig(8'h55);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v%b data %h link%b required v0 data 00 link0",
               rx_valid, rx_data, link_up);
    end
    gig(8'h55);
    gig(8'h55);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gig(8'h60 + 8'(i));
      checks++;
      if (rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet[%0d] rx_valid got %b required 0", i, rx_valid);
      end
    end
    idle();
    idle();
    for (int i = 0; i < 4; i++) begin
      gig(8'h70 + 8'(i));
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h70 + 8'(i)) begin
        errors++;
        $display("FAIL post_reset_frame[%0d] got v%b data %h required v1 data %h",
                 i, rx_valid, rx_data, 8'h70 + 8'(i));
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_gig_frame();
    test_mii_frame();
    test_mii_odd();
    test_gig_error();
    test_inband();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
